// File: rtl/sc_fir_sequencer.sv
// Stochastic-computing FIR sequencer: delay line, LFSR comparator source, window counter and result capture.
// Optional feature: define SC_LFSR_RESEED_EN to reload the LFSR with SEED at the start of every window.
module sc_fir_sequencer #(
  parameter int N = 8,
  parameter int ORDER = 9,
  parameter logic [N-1:0] SEED = 8'h01,
  parameter logic [N-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N-1:0]             sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  output logic [N*(ORDER+1)-1:0]   taps,
  output logic [N-1:0]             R_y,
  output logic [N-1:0]             sel_bits,
  output logic                     start,
  input  logic [N-1:0]             hwa_out,
  input  logic                     hwa_done,
  output logic [N-1:0]             result,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     sync_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [N-1:0] SEL_LAST = {N{1'b1}};
  localparam logic [N-1:0] SEL_ONE  = {{(N-1){1'b0}}, 1'b1};

  state_t                   state_q;
  logic [N*(ORDER+1)-1:0]   taps_q;
  logic [N-1:0]             lfsr_q;
  logic [N-1:0]             lfsr_d;
  logic [N-1:0]             sel_q;
  logic [N-1:0]             result_q;
  logic                     result_valid_q;
  logic                     sync_err_q;

  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
    return {s[N-2:0], ^(s & LFSR_TAPS)};
  endfunction

  assign lfsr_d = lfsr_step(lfsr_q);

  // Sequencer FSM together with every registered output it owns.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      taps_q         <= '0;
      lfsr_q         <= SEED;
      sel_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      sync_err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sample_valid) begin
            taps_q  <= {taps_q[N*ORDER-1:0], sample_in};
            state_q <= S_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD: begin
`ifdef SC_LFSR_RESEED_EN
          lfsr_q  <= SEED;
`endif
          sel_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          sel_q  <= sel_q + SEL_ONE;
          lfsr_q <= lfsr_d;
          // Done must coincide exactly with the last counter value of the window.
          if (sel_q == SEL_LAST) begin
            result_q       <= hwa_out;
            result_valid_q <= 1'b1;
            if (!hwa_done) begin
              sync_err_q <= 1'b1;
            end
            state_q <= S_HOLD;
          end else if (hwa_done) begin
            sync_err_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (result_ready) begin
            result_valid_q <= 1'b0;
            state_q        <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sample_ready = (state_q == S_IDLE) & ~reset;
  assign start        = (state_q == S_LOAD);
  assign taps         = taps_q;
  assign R_y          = lfsr_q;
  assign sel_bits     = sel_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_sc_fir_sequencer.sv
// Directed bench for sc_fir_sequencer with a comparator-counting HWA model.
// Expected LFSR sequences follow the macro SC_LFSR_RESEED_EN when it is defined for the build.
module tb_sc_fir_sequencer;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   sample_in = 8'h00;
  logic         sample_valid = 1'b0;
  logic         sample_ready;
  logic [79:0]  taps;
  logic [7:0]   R_y;
  logic [7:0]   sel_bits;
  logic         start;
  logic [7:0]   hwa_out;
  logic         hwa_done;
  logic [7:0]   result;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic         sync_err;

  int checks = 0;
  int failures = 0;
  int done_at = 255;
  int hwa_cyc;
  logic [7:0] hwa_cnt_q;
  logic       hit;
  logic [7:0] ref_seq [0:511];

  sc_fir_sequencer dut (
    .clock(clock), .reset(reset),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .taps(taps), .R_y(R_y), .sel_bits(sel_bits), .start(start),
    .hwa_out(hwa_out), .hwa_done(hwa_done),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .sync_err(sync_err)
  );

  always #5 clock = ~clock;

  // HWA model: one comparator on taps[0], running count including the current cycle.
  assign hit      = (R_y < taps[7:0]);
  assign hwa_out  = hwa_cnt_q + {7'd0, hit};
  assign hwa_done = (hwa_cyc == done_at);

  always @(posedge clock) begin
    if (reset) begin
      hwa_cyc   <= 2000;
      hwa_cnt_q <= 8'h00;
    end else if (start) begin
      hwa_cyc   <= 0;
      hwa_cnt_q <= 8'h00;
    end else begin
      hwa_cyc   <= hwa_cyc + 1;
      hwa_cnt_q <= hwa_cnt_q + {7'd0, hit};
    end
  end

  function automatic logic [7:0] ref_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    result_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Returns at the negedge of the LOAD cycle.
  task automatic send_sample(input logic [7:0] v);
    int t = 0;
    while (sample_ready !== 1'b1 && t < 600) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout: sample_ready=%b required 1", sample_ready);
    end
    sample_in = v;
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  task automatic wait_result();
    int t = 0;
    while (result_valid !== 1'b1 && t < 400) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (result_valid !== 1'b1) begin
      failures++;
      $display("FAIL result_timeout: result_valid=%b required 1", result_valid);
    end
  endtask

  task automatic finish_window();
    wait_result();
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    checks += 8;
    if (sample_ready !== 1'b0) begin failures++; $display("FAIL rst_sample_ready: got %b want 0", sample_ready); end
    if (R_y !== 8'h01) begin failures++; $display("FAIL rst_R_y: got %h want 01", R_y); end
    if (sel_bits !== 8'h00) begin failures++; $display("FAIL rst_sel_bits: got %h want 00", sel_bits); end
    if (start !== 1'b0) begin failures++; $display("FAIL rst_start: got %b want 0", start); end
    if (result !== 8'h00) begin failures++; $display("FAIL rst_result: got %h want 00", result); end
    if (result_valid !== 1'b0) begin failures++; $display("FAIL rst_result_valid: got %b want 0", result_valid); end
    if (sync_err !== 1'b0) begin failures++; $display("FAIL rst_sync_err: got %b want 0", sync_err); end
    if (taps !== 80'h0) begin failures++; $display("FAIL rst_taps: got %h want 0", taps); end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (sample_ready !== 1'b1) begin failures++; $display("FAIL idle_sample_ready: got %b want 1", sample_ready); end
  endtask

  task automatic test_single_sample();
    do_reset();
    result_ready = 1'b1;
    send_sample(8'h80);
    checks += 4;
    if (start !== 1'b1) begin failures++; $display("FAIL load_start: got %b want 1", start); end
    if (sel_bits !== 8'h00) begin failures++; $display("FAIL load_sel: got %h want 00", sel_bits); end
    if (taps[7:0] !== 8'h80) begin failures++; $display("FAIL load_tap0: got %h want 80", taps[7:0]); end
    if (sample_ready !== 1'b0) begin failures++; $display("FAIL load_ready: got %b want 0", sample_ready); end
    for (int k = 0; k < 256; k++) begin
      @(negedge clock);
      checks += 3;
      if (sel_bits !== k[7:0]) begin failures++; $display("FAIL run_sel k=%0d: got %0d want %0d", k, sel_bits, k); end
      if (start !== 1'b0) begin failures++; $display("FAIL run_start k=%0d: got %b want 0", k, start); end
      if (result_valid !== 1'b0) begin failures++; $display("FAIL run_valid k=%0d: got %b want 0", k, result_valid); end
    end
    @(negedge clock);
    checks += 4;
    if (result_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", result_valid); end
    if (result !== 8'd128) begin failures++; $display("FAIL single_result: got %0d want 128", result); end
    if (sync_err !== 1'b0) begin failures++; $display("FAIL single_sync_err: got %b want 0", sync_err); end
    if (sample_ready !== 1'b0) begin failures++; $display("FAIL hold_ready: got %b want 0", sample_ready); end
    @(negedge clock);
    checks += 2;
    if (sample_ready !== 1'b1) begin failures++; $display("FAIL back_idle: got %b want 1", sample_ready); end
    if (result_valid !== 1'b0) begin failures++; $display("FAIL valid_clear: got %b want 0", result_valid); end
    result_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int t = 0;
    do_reset();
    result_ready = 1'b1;
    send_sample(8'h55);
    while (sel_bits !== 8'd37 && t < 300) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (sel_bits !== 8'd37) begin failures++; $display("FAIL midrun_reach37: got %0d want 37", sel_bits); end
    reset = 1'b1;
    @(negedge clock);
    checks += 6;
    if (R_y !== 8'h01) begin failures++; $display("FAIL midrun_R_y: got %h want 01", R_y); end
    if (sel_bits !== 8'h00) begin failures++; $display("FAIL midrun_sel: got %h want 00", sel_bits); end
    if (result_valid !== 1'b0) begin failures++; $display("FAIL midrun_valid: got %b want 0", result_valid); end
    if (taps !== 80'h0) begin failures++; $display("FAIL midrun_taps: got %h want 0", taps); end
    if (start !== 1'b0) begin failures++; $display("FAIL midrun_start: got %b want 0", start); end
    if (sample_ready !== 1'b0) begin failures++; $display("FAIL midrun_ready_in_rst: got %b want 0", sample_ready); end
    reset = 1'b0;
    result_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (sample_ready !== 1'b1) begin failures++; $display("FAIL midrun_idle: got %b want 1", sample_ready); end
  endtask

  task automatic test_delay_line();
    do_reset();
    for (int s = 1; s <= 11; s++) begin
      send_sample(s[7:0]);
      if (s < 11) finish_window();
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (taps[i*8 +: 8] !== 8'(11 - i)) begin
        failures++;
        $display("FAIL delay_tap%0d: got %0d want %0d", i, taps[i*8 +: 8], 11 - i);
      end
    end
    finish_window();
  endtask

  task automatic test_backpressure();
    do_reset();
    send_sample(8'h40);
    wait_result();
    for (int c = 0; c < 20; c++) begin
      checks += 3;
      if (result !== 8'd64) begin failures++; $display("FAIL bp_result c=%0d: got %0d want 64", c, result); end
      if (result_valid !== 1'b1) begin failures++; $display("FAIL bp_valid c=%0d: got %b want 1", c, result_valid); end
      if (sample_ready !== 1'b0) begin failures++; $display("FAIL bp_ready c=%0d: got %b want 0", c, sample_ready); end
      @(negedge clock);
    end
    result_ready = 1'b1;
    checks++;
    if (result_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_at_hs: got %b want 1", result_valid); end
    @(negedge clock);
    checks += 2;
    if (sample_ready !== 1'b1) begin failures++; $display("FAIL bp_idle: got %b want 1", sample_ready); end
    if (result_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_clear: got %b want 0", result_valid); end
    result_ready = 1'b0;
  endtask

  task automatic check_sync(input string name, input logic want);
    checks++;
    if (sync_err !== want) begin failures++; $display("FAIL %s: sync_err=%b want %b", name, sync_err, want); end
  endtask

  task automatic test_misaligned();
    do_reset();
    done_at = 254;
    send_sample(8'h20);
    wait_result();
    check_sync("sync_early_done", 1'b1);
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    done_at = 255;
    for (int w = 0; w < 2; w++) begin
      send_sample(8'h30);
      wait_result();
      check_sync("sync_sticky", 1'b1);
      result_ready = 1'b1;
      @(negedge clock);
      result_ready = 1'b0;
    end
    do_reset();
    check_sync("sync_cleared", 1'b0);
    send_sample(8'h30);
    wait_result();
    check_sync("sync_clean", 1'b0);
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    done_at = 1000;
    send_sample(8'h30);
    wait_result();
    check_sync("sync_missing_done", 1'b1);
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    done_at = 255;
  endtask

  task automatic test_lfsr();
    logic [7:0] w1 [0:255];
    logic [7:0] w2 [0:255];
    int off;
    logic [7:0] e0, e1, e2;
`ifdef SC_LFSR_RESEED_EN
    off = 0;
    e0 = 8'h01; e1 = 8'h02; e2 = 8'h04;
`else
    off = 256;
    e0 = 8'h02; e1 = 8'h04; e2 = 8'h08;
`endif
    do_reset();
    result_ready = 1'b1;
    send_sample(8'h10);
    for (int k = 0; k < 256; k++) begin @(negedge clock); w1[k] = R_y; end
    @(negedge clock);
    @(negedge clock);
    send_sample(8'h11);
    for (int k = 0; k < 256; k++) begin @(negedge clock); w2[k] = R_y; end
    @(negedge clock);
    @(negedge clock);
    result_ready = 1'b0;
    checks += 7;
    if (w1[0] !== 8'h01) begin failures++; $display("FAIL lfsr_w1_0: got %h want 01", w1[0]); end
    if (w1[1] !== 8'h02) begin failures++; $display("FAIL lfsr_w1_1: got %h want 02", w1[1]); end
    if (w1[2] !== 8'h04) begin failures++; $display("FAIL lfsr_w1_2: got %h want 04", w1[2]); end
    if (w1[255] !== 8'h01) begin failures++; $display("FAIL lfsr_period: got %h want 01", w1[255]); end
    if (w2[0] !== e0) begin failures++; $display("FAIL lfsr_w2_0: got %h want %h", w2[0], e0); end
    if (w2[1] !== e1) begin failures++; $display("FAIL lfsr_w2_1: got %h want %h", w2[1], e1); end
    if (w2[2] !== e2) begin failures++; $display("FAIL lfsr_w2_2: got %h want %h", w2[2], e2); end
    for (int k = 0; k < 256; k++) begin
      checks += 2;
      if (w1[k] !== ref_seq[k]) begin failures++; $display("FAIL lfsr_w1 k=%0d: got %h want %h", k, w1[k], ref_seq[k]); end
      if (w2[k] !== ref_seq[off + k]) begin failures++; $display("FAIL lfsr_w2 k=%0d: got %h want %h", k, w2[k], ref_seq[off + k]); end
    end
  endtask

  initial begin
    ref_seq[0] = 8'h01;
    for (int j = 1; j < 512; j++) ref_seq[j] = ref_step(ref_seq[j-1]);
    test_reset();
    test_single_sample();
    test_reset_mid_run();
    test_delay_line();
    test_backpressure();
    test_misaligned();
    test_lfsr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_fir_sequencer.md
# sc_fir_sequencer

Drives one stochastic-computing FIR evaluation per input sample. It maintains the tap delay line and generates the comparator random numbers (`R_y`, from an LFSR), the mux-tree select counter (`sel_bits`) and the `start` pulse for the hardware-wide-adder datapath. It then captures the datapath's accumulated count as the filter result. It sits between the sample source and the HWA datapath, acting as the initiator for the HWA's bitstream window, and returns results through a valid/ready handshake.

## Interface
- `N`, 8: binary sample width; one evaluation window is 2^N cycles.
- `ORDER`, 9: filter order; the delay line holds ORDER+1 taps.
- `SEED`, 8'h01: LFSR reset/reseed value; must be nonzero.
- `LFSR_TAPS`, 8'hB8: Fibonacci feedback mask (x^8+x^6+x^5+x^4+1); maximal length for N=8.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `sample_in`, in, N: new input sample.
- `sample_valid`, in, 1: source has a sample.
- `sample_ready`, out, 1: sequencer accepts a sample this cycle.
- `taps`, out, N x (ORDER+1): delay line to the HWA `in[]`; `taps[0]` is the newest sample.
- `R_y`, out, N: random number, equal to the LFSR state.
- `sel_bits`, out, N: window counter.
- `start`, out, 1: one-cycle clear pulse to the HWA.
- `hwa_out`, in, N: HWA running count.
- `hwa_done`, in, 1: HWA end-of-window flag.
- `result`, out, N: captured filter output.
- `result_valid`, out, 1: result available.
- `result_ready`, in, 1: consumer takes the result.
- `sync_err`, out, 1: sticky flag; set on window misalignment.

## Operation
- States are IDLE, LOAD, RUN and HOLD.
- **IDLE**
  - `sample_ready`=1.
  - On `sample_valid` the sample is accepted and the FSM moves to LOAD.
- **LOAD** (1 cycle)
  - Delay line shifts: `taps[i]` <= `taps[i-1]`, `taps[0]` <= sample.
  - `start`=1 and `sel_bits`=0.
  - Next state is RUN.
- **RUN** (2^N cycles)
  - `sel_bits` increments each cycle, 0 through 2^N-1.
  - The LFSR advances each cycle.
  - On the cycle where `sel_bits`=2^N-1:
    - `hwa_out` is captured into `result`.
    - `hwa_done` is checked. If it is 0, `sync_err` is set. If `hwa_done`=1 on any earlier RUN cycle, `sync_err` is also set.
  - Next state is HOLD.
- **HOLD**
  - `result_valid`=1 until `result_ready`=1.
  - On handshake, go to IDLE.
- Outside RUN, `sel_bits` holds 0 and the LFSR holds its value.
- LFSR:
  - Shifts left by one.
  - New bit 0 is the XOR-reduce of (state & LFSR_TAPS).
  - All-zero is unreachable from a nonzero SEED.
- Arithmetic and widths:
  - `sel_bits` wraps modulo 2^N, but the FSM leaves RUN at the wrap, so 0 is never reissued within a window.
  - `result` is the raw N-bit count with no scaling.
- `sample_ready` is 0 in LOAD, RUN and HOLD. No input buffering: the source stalls.
- `sync_err` clears only on `reset`.
- Reset mid-window forces IDLE immediately. All outputs take their reset values and the partial window is discarded.

## Timing
- Reset values:
  - `sample_ready`=0 during reset, then 1 in the first IDLE cycle.
  - `taps`, `R_y`, `sel_bits`, `start`, `result`, `result_valid` and `sync_err` reset to all 0, except `R_y`=SEED.
- Accept at cycle T.
- T+1: LOAD, `start`=1.
- T+2 .. T+1+2^N: RUN.
- T+2+2^N: `result_valid`=1. Latency is 2^N+2 cycles.
- If `result_ready`=1 at T+2+2^N, the FSM is in IDLE at T+3+2^N. Minimum sample period is 2^N+3 cycles.
- `result` and `result_valid` are stable while stalled in HOLD.
- All outputs are registered except `sample_ready` and `start`, which are decoded directly from the FSM state.

## Configuration
- Macro: `SC_LFSR_RESEED_EN`.
- Defined: the LFSR reloads SEED in LOAD. Every window sees the identical `R_y` sequence, so results are deterministic per sample.
- Undefined: the LFSR free-runs across windows and only `reset` reloads SEED, which decorrelates successive windows.

## Test plan
- **Reset mid-RUN:** assert `reset` at `sel_bits`=37 -> next cycle the FSM is IDLE, `R_y`=8'h01, `sel_bits`=0, `result_valid`=0, and the delay line is cleared.
- **Single sample:** present 8'h80 with `result_ready`=1, using an HWA model that counts 128 -> `start` at T+1, `sel_bits` 0..255 over T+2..T+257, `result`=8'd128 with `result_valid` at T+258, `sync_err`=0.
- **Delay line:** feed 11 samples 1..11 -> after the 11th LOAD, `taps[0]`=11 and `taps[9]`=2, and sample 1 has been shifted out.
- **Backpressure:** hold `result_ready`=0 for 20 cycles after `result_valid` -> `result` is stable, `sample_ready`=0 throughout, and IDLE is entered the cycle after `result_ready` rises.
- **Misaligned done:** HWA model pulses `hwa_done` at `sel_bits`=254 -> `sync_err`=1 and stays 1 through later clean windows until `reset`.
- **LFSR:** with the macro defined, the `R_y` sequence over two consecutive windows is identical (starting 8'h01 -> 8'h02 -> 8'h04). With it undefined, the second window continues the sequence, and `R_y` period is 255.
